// File: rtl/edgedrnn_pkg.sv
// rtl/edgedrnn_pkg.sv - shared FSM encoding, terminator index and saturation helper for the delta encoder.
package edgedrnn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_t;

   // Callers truncate to their index width, so all-ones stays all-ones.
   localparam logic [63:0] TERM_IDX = '1;

   function automatic logic [63:0] sat_act(input logic signed [64:0] v, input int unsigned bw);
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      hi = (65'sd1 <<< (bw - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (bw - 1));
      if (v > hi) return hi[63:0];
      if (v < lo) return lo[63:0];
      return v[63:0];
   endfunction

endpackage

// File: rtl/edgedrnn_lsb_picker.sv
// rtl/edgedrnn_lsb_picker.sv - combinational lowest-set-bit encoder.
module edgedrnn_lsb_picker #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  bits,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/edgedrnn_delta_encoder.sv
// rtl/edgedrnn_delta_encoder.sv - delta encoder: thresholds lane changes against a per-beat
// previous-value store and streams the active lanes as {index, delta}.
module edgedrnn_delta_encoder
   import edgedrnn_pkg::*;
#(
   parameter int NUM_PE    = 8,
   parameter int ACT_BW    = 16,
   parameter int DTH_BW    = 10,
   parameter int NZI_BW    = 16,
   parameter int MAX_BEATS = 128
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DTH_BW-1:0]                cfg_dth,
   input  logic [$clog2(MAX_BEATS+1)-1:0]   cfg_num_beats,
   input  logic                             start,
   input  logic                             clr_state,
   output logic                             busy,
   output logic                             done,
   output logic                             err_len,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic [NUM_PE*ACT_BW-1:0]         s_axis_tdata,
   input  logic                             s_axis_tlast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [NZI_BW+ACT_BW-1:0]         m_axis_tdata,
   output logic                             m_axis_tlast
);

   localparam int NBW = $clog2(MAX_BEATS + 1);
   localparam int ABW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int PW  = $clog2(NUM_PE);

   state_t                   state, state_nx;
   logic [DTH_BW-1:0]        dth_q;
   logic [NBW-1:0]           nb_q;
   logic [NBW-1:0]           beat_cnt;
   logic [NZI_BW-1:0]        base_q;
   logic [NUM_PE-1:0]        mask;
   logic [NUM_PE-1:0]        act;
   logic                     last_q;
   logic signed [ACT_BW-1:0] prev    [MAX_BEATS][NUM_PE];
   logic signed [ACT_BW-1:0] delta_q [NUM_PE];
   logic signed [ACT_BW-1:0] sat     [NUM_PE];
   logic [PW-1:0]            pick_idx;
   logic                     pick_valid;
   logic                     accept, out_fire, count_hit, beat_last, single;
   logic [ABW-1:0]           addr;

   assign s_axis_tready = (state == RUN);
   assign busy          = (state != IDLE);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign out_fire      = m_axis_tvalid && m_axis_tready;
   assign addr          = beat_cnt[ABW-1:0];
   assign count_hit     = ((beat_cnt + NBW'(1)) == nb_q);
   assign beat_last     = count_hit || s_axis_tlast;
   assign single        = ((mask & (mask - NUM_PE'(1))) == '0);

   for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
      logic signed [ACT_BW-1:0] x;
      logic signed [ACT_BW-1:0] p;
      logic signed [ACT_BW:0]   diff;
      logic [ACT_BW:0]          mag;
      assign x        = s_axis_tdata[g*ACT_BW +: ACT_BW];
      assign p        = prev[addr][g];
      assign diff     = (ACT_BW+1)'(x) - (ACT_BW+1)'(p);
      assign mag      = diff[ACT_BW] ? -diff : diff;
      assign act[g]   = (mag >= (ACT_BW+1)'(dth_q));
      assign sat[g]   = ACT_BW'(sat_act(65'(diff), ACT_BW));
   end

   edgedrnn_lsb_picker #(.N(NUM_PE), .IW(PW)) u_picker (
      .bits  (mask),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && cfg_num_beats != '0) state_nx = RUN;
         RUN:     if (accept) begin
                     if (|act)          state_nx = DRAIN;
                     else if (beat_last) state_nx = FLUSH;
                  end
         DRAIN:   if (out_fire && single) state_nx = last_q ? IDLE : RUN;
         FLUSH:   if (out_fire) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      case (state)
         DRAIN: begin
            m_axis_tvalid = pick_valid;
            m_axis_tlast  = last_q && single;
            m_axis_tdata  = {base_q + NZI_BW'(pick_idx), delta_q[pick_idx]};
         end
         FLUSH: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tdata  = {NZI_BW'(TERM_IDX), {ACT_BW{1'b0}}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dth_q    <= '0;
         nb_q     <= '0;
         beat_cnt <= '0;
         base_q   <= '0;
         mask     <= '0;
         last_q   <= 1'b0;
         done     <= 1'b0;
         err_len  <= 1'b0;
         for (int i = 0; i < NUM_PE; i++) delta_q[i] <= '0;
      end else begin
         state <= state_nx;
         // Zero-length vectors finish straight from IDLE without ever leaving it.
         done  <= (state != IDLE && state_nx == IDLE) ||
                  (state == IDLE && start && cfg_num_beats == '0);
         if (state == IDLE && start) begin
            dth_q    <= cfg_dth;
            nb_q     <= cfg_num_beats;
            beat_cnt <= '0;
            err_len  <= 1'b0;
         end
         if (accept) begin
            beat_cnt <= beat_cnt + NBW'(1);
            base_q   <= NZI_BW'(32'(beat_cnt) * NUM_PE);
            mask     <= act;
            last_q   <= beat_last;
            for (int i = 0; i < NUM_PE; i++) delta_q[i] <= sat[i];
            if (count_hit != s_axis_tlast) err_len <= 1'b1;
         end else if (state == DRAIN && out_fire) begin
            mask[pick_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && clr_state)) begin
         for (int b = 0; b < MAX_BEATS; b++)
            for (int i = 0; i < NUM_PE; i++) prev[b][i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_PE; i++)
            if (act[i]) prev[addr][i] <= s_axis_tdata[i*ACT_BW +: ACT_BW];
      end
   end

endmodule

// File: doc/edgedrnn_delta_encoder.md
EDGEDRNN_DELTA_ENCODER -- requirements
Module: edgedrnn_delta_encoder

Interface
REQ-001 SHALL have parameter NUM_PE, default 8: activation lanes per input beat (>= 2).
REQ-002 SHALL have parameter ACT_BW, default 16: signed activation width (integer plus fraction bits).
REQ-003 SHALL have parameter DTH_BW, default 10: unsigned delta-threshold width (<= ACT_BW).
REQ-004 SHALL have parameter NZI_BW, default 16: nonzero-index width.
REQ-005 SHALL have parameter MAX_BEATS, default 128: depth of the previous-value store, in beats.
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have these configuration and control ports:
- cfg_dth  in  DTH_BW  delta threshold.
- cfg_num_beats  in  clog2(MAX_BEATS+1)  beats per vector.
- start  in  1  start-of-vector pulse.
- clr_state  in  1  zero the previous-value store.
- busy  out  1  encoder is active.
- done  out  1  one-cycle completion pulse.
- err_len  out  1  sticky length-mismatch flag.
REQ-008 SHALL have this input stream:
- s_axis_tvalid  in  1.
- s_axis_tready  out  1.
- s_axis_tdata  in  NUM_PE*ACT_BW  lane 0 in the LSBs.
- s_axis_tlast  in  1.
REQ-009 SHALL have this output stream:
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tdata  out  NZI_BW+ACT_BW  {index, delta}.
- m_axis_tlast  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DRAIN and FLUSH.
REQ-011 SHALL, on start in IDLE, latch cfg_dth and cfg_num_beats, clear the beat counter, clear err_len and go to RUN. start outside IDLE SHALL be ignored.
REQ-012 SHALL, when start arrives with cfg_num_beats=0, pulse done on the next cycle, emit no output and stay in IDLE.
REQ-013 SHALL drive s_axis_tready high only in RUN. A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high.
REQ-014 SHALL, per accepted lane i, compute diff = x - prev[beat][i] at ACT_BW+1 bits. The lane is active when |diff| >= cfg_dth, zero-extended.
REQ-015 SHALL emit each active lane's delta saturated to signed ACT_BW. The same cycle SHALL write x into prev for that lane; inactive lanes keep their prev value.
REQ-016 SHALL compute an active lane's index as beat*NUM_PE + i, truncated to NZI_BW.
REQ-017 SHALL, after an accepted beat with a nonzero active mask, go to DRAIN. With an empty mask, the next state SHALL depend on whether the beat is the last: not last stays in RUN; last goes to FLUSH.
REQ-018 SHALL, in DRAIN, present the lowest set mask bit, registered, with first m_axis_tvalid one cycle after acceptance.
REQ-019 SHALL keep m_axis_tdata stable while m_axis_tvalid is high and m_axis_tready is low. Each handshake SHALL clear one mask bit, giving one output per cycle.
REQ-020 SHALL, when the mask empties, return to RUN, or to IDLE if the beat was the last.
REQ-021 SHALL set m_axis_tlast on the final active lane of the last beat.
REQ-022 SHALL, in FLUSH, emit a terminator {all-ones index, delta 0} with tlast, then go to IDLE.
REQ-023 SHALL pulse done for one cycle on entry to IDLE from DRAIN or FLUSH.
REQ-024 SHALL treat a beat as the last when the beat count reaches cfg_num_beats or s_axis_tlast=1, whichever is first. err_len SHALL be set if these two conditions disagree.
REQ-025 SHALL, with cfg_dth=0, mark every lane active (dense mode).
REQ-026 SHALL, on clr_state in IDLE, zero all prev entries in one cycle. clr_state outside IDLE SHALL be ignored.
REQ-027 SHALL hold busy high in every state except IDLE.

Reset
REQ-028 SHALL, on rst, put the FSM in IDLE and zero the counters, mask, prev store, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done and err_len.
REQ-029 SHALL, on rst mid-vector, abort immediately with no done pulse and no terminator.

Structure
REQ-030 SHALL place the FSM state encoding, the terminator index constant and a saturation helper in package edgedrnn_pkg.
REQ-031 SHALL use one sub-module, edgedrnn_lsb_picker: a combinational lowest-set-bit encoder that outputs an index and a valid.

Verification
REQ-032 SHALL cover: NUM_PE=4, dth=16, prev=0, beat {0,20,5,-17}, num_beats=1 -> (1,20) then (3,-17) with tlast, then done.
REQ-033 SHALL cover: repeat the same beat -> all lanes inactive -> terminator {0xFFFF,0} with tlast.
REQ-034 SHALL cover: prev=-32768, x=32767, dth=1 -> delta 32767, saturated.
REQ-035 SHALL cover: m_axis_tready held low for 5 cycles mid-DRAIN -> tdata stable; no loss or duplication.
REQ-036 SHALL cover: num_beats=3 with s_axis_tlast on beat 2 -> vector ends after beat 2 and err_len=1.
REQ-037 SHALL cover: rst asserted in DRAIN -> next cycle IDLE, tvalid=0, prev all zero, no done.
